// File: rtl/l1_l2_arbiter_pkg.sv
// Shared types for the L1 -> L2 port arbiter.
package l1_l2_arbiter_pkg;

    localparam int LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    typedef enum logic {
        XFER_READ,
        XFER_WRITE
    } arb_type_t;

    function automatic logic [3:0] streak_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/l1_l2_arbiter_select.sv
// Winner pick between icache and dcache.
// dcache wins unless its streak has starved a waiting icache.
module l1_arb_select
    import l1_l2_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic       i_req,
    input  logic       d_req,
    input  logic [3:0] streak,
    output logic       grant_i,
    output logic       grant_d
);

    logic force_i;

    always_comb begin
        force_i = i_req && (streak == 4'(MAX_D_STREAK));
        grant_i = i_req && (!d_req || force_i);
        grant_d = d_req && !grant_i;
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Single-outstanding arbiter sharing the L2 port between icache and dcache.
// Optional perf counters enabled by L1_L2_ARB_PERF_EN.
module l1_l2_arbiter
    import l1_l2_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_read,
    input  logic [31:0]           icache_addr,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [31:0]           dcache_addr,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [31:0]           l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
`ifdef L1_L2_ARB_PERF_EN
    ,
    output logic [31:0]           arb_i_grants,
    output logic [31:0]           arb_d_grants,
    output logic [31:0]           arb_stall_cycles
`endif
);

    arb_state_t            state_q, state_d;
    arb_owner_t            owner_q, owner_d;
    arb_type_t             type_q, type_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            streak_q, streak_d;

    logic d_req;
    logic grant_i;
    logic grant_d;
    logic busy;

    assign d_req = dcache_read | dcache_write;

    l1_arb_select #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_select (
        .i_req  (icache_read),
        .d_req  (d_req),
        .streak (streak_q),
        .grant_i(grant_i),
        .grant_d(grant_d)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        type_d   = type_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        streak_d = streak_q;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d  = GRANT_I;
                    owner_d  = OWN_I;
                    type_d   = XFER_READ;
                    addr_d   = icache_addr;
                    streak_d = 4'd0;
                end else if (grant_d) begin
                    state_d  = GRANT_D;
                    owner_d  = OWN_D;
                    type_d   = dcache_write ? XFER_WRITE : XFER_READ;
                    addr_d   = dcache_addr;
                    wdata_d  = dcache_wdata;
                    streak_d = icache_read ? streak_inc(streak_q) : 4'd0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (l2_resp) begin
                    if (type_q == XFER_READ) begin
                        rdata_d = l2_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q == GRANT_I) || (state_q == GRANT_D);
        l2_read      = busy && (type_q == XFER_READ);
        l2_write     = busy && (type_q == XFER_WRITE);
        l2_address   = addr_q;
        l2_wdata     = wdata_q;
        icache_resp  = (state_q == DONE) && (owner_q == OWN_I);
        dcache_resp  = (state_q == DONE) && (owner_q == OWN_D);
        icache_rdata = rdata_q;
        dcache_rdata = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            type_q   <= XFER_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            streak_q <= streak_d;
        end
    end

`ifdef L1_L2_ARB_PERF_EN
    logic [31:0] i_grants_q, i_grants_d;
    logic [31:0] d_grants_q, d_grants_d;
    logic [31:0] stall_q, stall_d;
    logic        own_i;
    logic        own_d;

    // A requester is served from its grant until its resp cycle.
    always_comb begin
        own_i      = (state_q != IDLE) && (owner_q == OWN_I);
        own_d      = (state_q != IDLE) && (owner_q == OWN_D);
        i_grants_d = i_grants_q;
        d_grants_d = d_grants_q;
        stall_d    = stall_q;
        if (state_q == IDLE && grant_i) begin
            i_grants_d = i_grants_q + 32'd1;
        end
        if (state_q == IDLE && grant_d) begin
            d_grants_d = d_grants_q + 32'd1;
        end
        if ((icache_read && !own_i) || (d_req && !own_d)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_grants_q <= '0;
            d_grants_q <= '0;
            stall_q    <= '0;
        end else begin
            i_grants_q <= i_grants_d;
            d_grants_q <= d_grants_d;
            stall_q    <= stall_d;
        end
    end

    assign arb_i_grants     = i_grants_q;
    assign arb_d_grants     = d_grants_q;
    assign arb_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed self-checking bench for l1_l2_arbiter.
module tb_l1_l2_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         icache_read;
    logic [31:0]  icache_addr;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_addr;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;
`ifdef L1_L2_ARB_PERF_EN
    logic [31:0]  arb_i_grants;
    logic [31:0]  arb_d_grants;
    logic [31:0]  arb_stall_cycles;
`endif

    l1_l2_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .icache_read (icache_read),
        .icache_addr (icache_addr),
        .icache_rdata(icache_rdata),
        .icache_resp (icache_resp),
        .dcache_read (dcache_read),
        .dcache_write(dcache_write),
        .dcache_addr (dcache_addr),
        .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata),
        .dcache_resp (dcache_resp),
        .l2_read     (l2_read),
        .l2_write    (l2_write),
        .l2_address  (l2_address),
        .l2_wdata    (l2_wdata),
        .l2_rdata    (l2_rdata),
        .l2_resp     (l2_resp)
`ifdef L1_L2_ARB_PERF_EN
        ,
        .arb_i_grants    (arb_i_grants),
        .arb_d_grants    (arb_d_grants),
        .arb_stall_cycles(arb_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           i_rd;
        bit           d_rd;
        bit           d_wr;
        logic [31:0]  i_addr;
        logic [31:0]  d_addr;
        logic [255:0] wdata;
        logic [255:0] line;
        int           delay;
        bit           e_own;
        bit           e_wr;
        logic [31:0]  e_addr;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    int checks = 0;
    int failures = 0;
    logic [255:0] exp_rdata;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {l2_read, l2_write, icache_resp, dcache_resp}, 4'b0000);
    endtask

    // Waits for the strobe, plays L2 with the given delay, checks DONE.
    task automatic txn(input string name, input bit own_d, input bit wr,
                       input logic [31:0] addr, input logic [255:0] wdata,
                       input logic [255:0] line, input int delay,
                       input int exp_wait, input bit scramble);
        int  w;
        bit  seen;
        w = 0;
        seen = 1'b0;
        while (!seen && w < 20) begin
            step();
            w++;
            if (w == 1)
                chk({name, " resp_clear"}, {icache_resp, dcache_resp}, 2'b00);
            if (l2_read || l2_write) seen = 1'b1;
        end
        if (!seen) begin
            chk({name, " grant_timeout"}, 1'b0, 1'b1);
            return;
        end
        chk({name, " grant_wait"}, w, exp_wait);
        chk({name, " strobe"}, {l2_read, l2_write}, {!wr, wr});
        chk({name, " addr"}, l2_address, addr);
        if (wr) chk({name, " wdata"}, l2_wdata, wdata);
        if (scramble) begin
            icache_addr  = ~icache_addr;
            dcache_addr  = ~dcache_addr;
            dcache_wdata = ~dcache_wdata;
        end
        for (int k = 0; k < delay; k++) begin
            step();
            chk({name, " hold"},
                {l2_read | l2_write, icache_resp | dcache_resp}, 2'b10);
        end
        l2_resp  = 1'b1;
        l2_rdata = line;
        step();
        l2_resp  = 1'b0;
        l2_rdata = ~line;
        chk({name, " resp"}, {icache_resp, dcache_resp}, {!own_d, own_d});
        chk({name, " done_strobe"}, {l2_read, l2_write}, 2'b00);
        if (!wr) exp_rdata = line;
        chk({name, " rdata"}, own_d ? dcache_rdata : icache_rdata, exp_rdata);
        chk({name, " addr_latched"}, l2_address, addr);
        if (wr) chk({name, " wdata_latched"}, l2_wdata, wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d_a;
        int          d_left;
        bit          own_seq [6];

        vecs[0] = '{1, 0, 0, 32'h0000_1000, 32'h0, '0,
                    {8{32'hA5A5_A5A5}}, 3, 0, 0, 32'h0000_1000};
        vecs[1] = '{0, 1, 0, 32'h0, 32'h0000_0080, {8{32'h1111_2222}},
                    {8{32'hDEAD_BEEF}}, 0, 1, 0, 32'h0000_0080};
        vecs[2] = '{0, 0, 1, 32'h0, 32'h0000_2000, {8{32'h1234_5678}},
                    {8{32'h0BAD_0BAD}}, 1, 1, 1, 32'h0000_2000};
        vecs[3] = '{0, 1, 1, 32'h0, 32'h0000_0040, {8{32'hCAFE_F00D}},
                    {8{32'h5555_5555}}, 2, 1, 1, 32'h0000_0040};
        vecs[4] = '{1, 0, 0, 32'hFFFF_FFE0, 32'h0, '0,
                    {8{32'h0F0F_0F0F}}, 5, 0, 0, 32'hFFFF_FFE0};

        reset = 1'b1;
        icache_read = 1'b0;
        icache_addr = '0;
        dcache_read = 1'b0;
        dcache_write = 1'b0;
        dcache_addr = '0;
        dcache_wdata = '0;
        l2_rdata = '0;
        l2_resp = 1'b0;
        exp_rdata = '0;
        step();
        step();
        chk_quiet("rst_outputs");
        chk("rst_addr", l2_address, 32'h0);
        chk("rst_wdata", l2_wdata, 256'h0);
        chk("rst_rdata", icache_rdata, 256'h0);
        reset = 1'b0;
        step();
        chk_quiet("post_rst_idle");

        for (int i = 0; i < NV; i++) begin
            icache_read  = vecs[i].i_rd;
            dcache_read  = vecs[i].d_rd;
            dcache_write = vecs[i].d_wr;
            icache_addr  = vecs[i].i_addr;
            dcache_addr  = vecs[i].d_addr;
            dcache_wdata = vecs[i].wdata;
            txn($sformatf("v%0d", i), vecs[i].e_own, vecs[i].e_wr,
                vecs[i].e_addr, vecs[i].wdata, vecs[i].line,
                vecs[i].delay, 1, 1'b1);
            icache_read  = 1'b0;
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
            step();
            chk_quiet($sformatf("v%0d idle_after", i));
        end

        l2_resp = 1'b1;
        step();
        l2_resp = 1'b0;
        chk_quiet("stray_resp_1");
        step();
        chk_quiet("stray_resp_2");

        // Simultaneous requests: dcache first, icache next.
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_rdata = '0;
        icache_read  = 1'b1;
        icache_addr  = 32'h0000_3000;
        dcache_write = 1'b1;
        dcache_addr  = 32'h0000_2000;
        dcache_wdata = {8{32'h1234_5678}};
        txn("s2_d", 1, 1, 32'h0000_2000, {8{32'h1234_5678}},
            {8{32'h7777_7777}}, 1, 1, 1'b0);
        dcache_write = 1'b0;
        txn("s2_i", 0, 0, 32'h0000_3000, '0, {8{32'h3C3C_3C3C}},
            1, 2, 1'b0);
        icache_read = 1'b0;
        step();
        chk_quiet("s2_idle");
`ifdef L1_L2_ARB_PERF_EN
        chk("perf_i_grants", arb_i_grants, 32'd1);
        chk("perf_d_grants", arb_d_grants, 32'd1);
        chk("perf_stall", arb_stall_cycles, 32'd5);
`endif

        // Streak limit: D,D,D,D,I,D with MAX_D_STREAK = 4.
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_rdata = '0;
        own_seq = '{1, 1, 1, 1, 0, 1};
        d_a = 32'h0000_6000;
        d_left = 5;
        icache_read = 1'b1;
        icache_addr = 32'h0000_5000;
        dcache_read = 1'b1;
        dcache_addr = d_a;
        for (int k = 0; k < 6; k++) begin
            if (own_seq[k]) begin
                txn($sformatf("streak%0d_d", k), 1, 0, d_a, '0,
                    {8{32'h6000_0000 + k}}, 1, (k == 0) ? 1 : 2, 1'b0);
                d_left--;
                d_a = d_a + 32'h20;
                dcache_addr = d_a;
                if (d_left == 0) dcache_read = 1'b0;
            end else begin
                txn($sformatf("streak%0d_i", k), 0, 0, 32'h0000_5000, '0,
                    {8{32'h5000_0000 + k}}, 1, 2, 1'b0);
                icache_read = 1'b0;
            end
        end
        step();
        chk_quiet("streak_idle");

        // Reset two cycles into GRANT_D abandons the transaction.
        dcache_read = 1'b1;
        dcache_addr = 32'h0000_7000;
        step();
        chk("rst_mid_grant", {l2_read, l2_write}, 2'b10);
        step();
        reset = 1'b1;
        dcache_read = 1'b0;
        step();
        reset = 1'b0;
        chk_quiet("rst_mid_abandon");
        step();
        chk_quiet("rst_mid_no_resp");
        exp_rdata = '0;
        chk("rst_mid_rdata", dcache_rdata, 256'h0);
        icache_read = 1'b1;
        icache_addr = 32'h0000_8000;
        txn("s5_i", 0, 0, 32'h0000_8000, '0, {8{32'h8888_9999}},
            2, 1, 1'b0);
        icache_read = 1'b0;
        step();
        chk_quiet("s5_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
